// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared encodings and width helpers for the tri-state bus arbiter.
package tristate_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_TURN  = 2'd2;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s + 0;
    end
    return W'(s);
  endfunction

  // Scan from the farthest offset down so the closest hit to ptr is written last.
  always_comb begin
    valid = 1'b0;
    index = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      index = req[wrap_idx(ptr, i)] ? wrap_idx(ptr, i) : index;
      valid = valid | req[wrap_idx(ptr, i)];
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state net with an all-off turnaround
// gap between owners. Define TRISTATE_BUS_TIMEOUT_EN to preempt long holders.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         outEnable,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int OW = $clog2(N_REQ);
  localparam int TW = idx_width(TURNAROUND);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  if (N_REQ < 2 || N_REQ > 16 || TURNAROUND < 1 || MAX_HOLD < 1) begin : g_bad_params
    $error("tristate_bus_arbiter: parameter out of range");
  end

  state_t           state;
  state_t           state_next;
  logic [OW-1:0]    owner_next;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    rr_ptr_next;
  logic [TW-1:0]    turn_cnt;
  logic [TW-1:0]    turn_cnt_next;
  logic             pick_valid;
  logic [OW-1:0]    pick_index;
  logic [N_REQ-1:0] owner_mask;
  logic             owner_release;
  logic             leave_grant;
  logic [N_REQ-1:0] grant_next;
  logic             busy_next;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] i);
    if (i == OW'(N_REQ - 1)) begin
      return {OW{1'b0}};
    end else begin
      return i + OW'(1);
    end
  endfunction

  rr_pick #(
    .N (N_REQ),
    .W (OW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_index)
  );

  assign owner_mask    = onehot(owner);
  assign owner_release = ~|(req & owner_mask);

`ifdef TRISTATE_BUS_TIMEOUT_EN
  localparam int HW = idx_width(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_next;
  logic [HW-1:0] hold_sat;
  logic          others_pending;

  // Hold count after this GRANT cycle; reaching MAX_HOLD ends the 8th cycle, not the 9th.
  assign hold_sat       = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
  assign others_pending = |(req & ~owner_mask);
  assign leave_grant    = owner_release | ((hold_sat == HOLD_MAX) & others_pending);
`else
  assign leave_grant    = owner_release;
`endif

  // State register: FSM state, owner, round-robin pointer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= {OW{1'b0}};
      rr_ptr   <= {OW{1'b0}};
      turn_cnt <= {TW{1'b0}};
`ifdef TRISTATE_BUS_TIMEOUT_EN
      hold_cnt <= {HW{1'b0}};
`endif
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_ptr_next;
      turn_cnt <= turn_cnt_next;
`ifdef TRISTATE_BUS_TIMEOUT_EN
      hold_cnt <= hold_cnt_next;
`endif
    end
  end

  // Next-state logic: a new owner is only ever picked from IDLE or the last TURN cycle.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rr_ptr_next   = rr_ptr;
    turn_cnt_next = turn_cnt;
`ifdef TRISTATE_BUS_TIMEOUT_EN
    hold_cnt_next = hold_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next = ST_GRANT;
          owner_next = pick_index;
`ifdef TRISTATE_BUS_TIMEOUT_EN
          hold_cnt_next = {HW{1'b0}};
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
`ifdef TRISTATE_BUS_TIMEOUT_EN
        hold_cnt_next = hold_sat;
`endif
        if (leave_grant) begin
          state_next    = ST_TURN;
          rr_ptr_next   = ptr_after(owner);
          turn_cnt_next = {TW{1'b0}};
        end else begin
          state_next = ST_GRANT;
        end
      end
      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          if (pick_valid) begin
            state_next = ST_GRANT;
            owner_next = pick_index;
`ifdef TRISTATE_BUS_TIMEOUT_EN
            hold_cnt_next = {HW{1'b0}};
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          turn_cnt_next = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    grant_next = {N_REQ{1'b0}};
    busy_next  = 1'b0;
    if (state_next == ST_GRANT) begin
      grant_next = onehot(owner_next);
      busy_next  = 1'b1;
    end else if (state_next == ST_TURN) begin
      busy_next = 1'b1;
    end else begin
      busy_next = 1'b0;
    end
  end

  // Output flops; reset turns every buffer off immediately so the net floats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= {N_REQ{1'b0}};
      outEnable <= {N_REQ{1'b0}};
      busy      <= 1'b0;
    end else begin
      grant     <= grant_next;
      outEnable <= grant_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N_REQ=4, TURNAROUND=1, MAX_HOLD=8)
// plus a random contention sweep; timeout vectors follow TRISTATE_BUS_TIMEOUT_EN.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] outEnable;
  logic [1:0] owner;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N_REQ      (4),
    .TURNAROUND (1),
    .MAX_HOLD   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .outEnable (outEnable),
    .owner     (owner),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_oe"}, outEnable, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    int viol;
    int changes;
    int zero_run;
    logic [3:0] last_oe;

    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_idle("por");
    step(2);
    rst = 1'b0;

    // Single requester: one-cycle latency, release, one TURN cycle, then IDLE.
    req = 4'b0100;
    check("single_pre_edge_oe", outEnable, 0);
    step(1);
    check("single_oe", outEnable, 4'b0100);
    check("single_grant", grant, 4'b0100);
    check("single_owner", owner, 2);
    check("single_busy", busy, 1);
    req = 4'b0111;
    step(1);
    check("others_no_effect_oe", outEnable, 4'b0100);
    req = 4'b0000;
    step(1);
    check("single_turn_oe", outEnable, 0);
    check("single_turn_busy", busy, 1);
    step(1);
    check("single_idle_busy", busy, 0);
    check("single_idle_oe", outEnable, 0);

    // Pointer now 3: 1001 picks 3, then after 3 releases 1001 must pick 0.
    req = 4'b1001;
    step(1);
    check("wrap_first_owner", owner, 3);
    req = 4'b0001;
    step(1);
    check("wrap_gap_oe", outEnable, 0);
    req = 4'b1001;
    step(1);
    check("wrap_owner", owner, 0);
    check("wrap_oe", outEnable, 4'b0001);
    req = 4'b0000;
    step(1);
    req = 4'b0001;
    step(1);
    check("rewin_sole_owner", owner, 0);
    check("rewin_sole_oe", outEnable, 4'b0001);
    req = 4'b0000;
    step(2);

    // Round robin with all four requesting, each owner holding two cycles.
    do_reset();
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      check("rr_owner", owner, k % 4);
      check("rr_oe", outEnable, oh(k % 4));
      step(1);
      check("rr_hold2_oe", outEnable, oh(k % 4));
      req = 4'b1111 & ~oh(k % 4);
      step(1);
      check("rr_gap_oe", outEnable, 0);
      check("rr_gap_busy", busy, 1);
      req = 4'b1111;
      step(1);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0010;
    step(1);
    check("pre_reset_oe", outEnable, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    step(1);
    rst = 1'b0;
    req = 4'b0000;

    // Long hold by requester 1 with requester 2 arriving during the grant.
    do_reset();
    req = 4'b0010;
    step(1);
    for (int i = 1; i <= 8; i++) begin
      check("hold_oe", outEnable, 4'b0010);
      if (i == 3) req = 4'b0110;
      step(1);
    end
`ifdef TRISTATE_BUS_TIMEOUT_EN
    check("timeout_gap_oe", outEnable, 0);
    step(1);
    check("timeout_new_owner", owner, 2);
    check("timeout_new_oe", outEnable, 4'b0100);
    do_reset();
    req = 4'b0010;
    step(12);
    check("solo_hold_oe", outEnable, 4'b0010);
    req = 4'b1010;
    step(1);
    check("sat_preempt_oe", outEnable, 0);
    step(1);
    check("sat_preempt_owner", owner, 3);
`else
    check("no_timeout_oe", outEnable, 4'b0010);
    step(4);
    check("no_timeout_late_oe", outEnable, 4'b0010);
    check("no_timeout_owner", owner, 1);
`endif

    // Random request traffic: enables one-hot, gap before every owner change.
    do_reset();
    viol = 0;
    changes = 0;
    zero_run = 0;
    last_oe = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      step(1);
      if (!$onehot0(outEnable)) viol++;
      if (grant !== outEnable) viol++;
      if (outEnable == 4'b0000) begin
        zero_run++;
      end else begin
        if (outEnable != oh(int'(owner)) || !busy) viol++;
        if (last_oe != 4'b0000 && outEnable != last_oe) begin
          changes++;
          if (zero_run < 1) viol++;
        end
        last_oe = outEnable;
        zero_run = 0;
      end
    end
    check("random_contention_violations", viol, 0);
    check("random_owner_changes_seen", changes > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
